// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the stream loader state type.
package ahb_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

   localparam logic [2:0] HSIZE_BYTE = 3'b000;
   localparam logic [2:0] HSIZE_HALF = 3'b001;
   localparam logic [2:0] HSIZE_WORD = 3'b010;

   typedef enum logic [2:0] {
      IDLE,
      COLLECT,
      ADDR,
      DATA,
      DONE
   } loader_state_t;

endpackage

// File: rtl/ahb_stream_loader_packer.sv
// Packs an 8-bit valid/ready stream little-endian into 32-bit words; the fourth
// byte is presented combinationally on word_valid together with the first three.
module ahb_stream_loader_packer (
   input  logic        HCLK,
   input  logic        HRESET,
   input  logic        clear,
   input  logic        enable,
   input  logic [7:0]  s_data,
   input  logic        s_valid,
   output logic        s_ready,
   output logic [31:0] word,
   output logic        word_valid,
   input  logic        word_ack
);

   logic [1:0]  byte_idx;
   logic [23:0] lanes;

   // The last byte is only taken when the consumer acknowledges the word.
   assign s_ready    = enable && ((byte_idx != 2'd3) || word_ack);
   assign word_valid = enable && s_valid && (byte_idx == 2'd3);
   assign word       = {s_data, lanes};

   always_ff @(posedge HCLK) begin
      if (HRESET || clear) begin
         byte_idx <= 2'd0;
         lanes    <= 24'd0;
      end else if (s_valid && s_ready) begin
         case (byte_idx)
            2'd0:    lanes[7:0]   <= s_data;
            2'd1:    lanes[15:8]  <= s_data;
            2'd2:    lanes[23:16] <= s_data;
            default: lanes        <= lanes;
         endcase
         byte_idx <= byte_idx + 2'd1;
      end
   end

endmodule

// File: rtl/ahb_stream_loader.sv
// AHB-Lite write-only boot loader: streams bytes into SRAM as single NONSEQ word writes.
// Optional running checksum output under `AHB_STREAM_LOADER_CHECKSUM_EN.
module ahb_stream_loader
   import ahb_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int          LEN_WORDS = 256,
   parameter int          CNT_W     = 16
) (
   input  logic             HCLK,
   input  logic             HRESET,
   input  logic             start,
   input  logic [7:0]       s_data,
   input  logic             s_valid,
   output logic             s_ready,
   output logic [31:0]      HADDR,
   output logic [1:0]       HTRANS,
   output logic             HWRITE,
   output logic [2:0]       HSIZE,
   output logic [31:0]      HWDATA,
   input  logic             HREADY,
   output logic             busy,
   output logic             done,
`ifdef AHB_STREAM_LOADER_CHECKSUM_EN
   output logic [CNT_W-1:0] word_count,
   output logic [31:0]      checksum
`else
   output logic [CNT_W-1:0] word_count
`endif
);

   localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(LEN_WORDS - 1);

   loader_state_t state;
   loader_state_t next_state;

   logic        start_ok;
   logic        collecting;
   logic [31:0] packed_word;
   logic        word_valid;
   logic        data_done;

   assign start_ok   = start && ((state == IDLE) || (state == DONE));
   assign collecting = (state == COLLECT);
   assign data_done  = (state == DATA) && HREADY;

   ahb_stream_loader_packer u_packer (
      .HCLK       (HCLK),
      .HRESET     (HRESET),
      .clear      (start_ok),
      .enable     (collecting),
      .s_data     (s_data),
      .s_valid    (s_valid),
      .s_ready    (s_ready),
      .word       (packed_word),
      .word_valid (word_valid),
      .word_ack   (collecting)
   );

   always_ff @(posedge HCLK) begin
      if (HRESET) state <= IDLE;
      else        state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (start) next_state = COLLECT;
         COLLECT: if (word_valid) next_state = ADDR;
         ADDR:    if (HREADY) next_state = DATA;
         DATA:    if (HREADY) next_state = (word_count == LAST_COUNT) ? DONE : COLLECT;
         DONE:    if (start) next_state = COLLECT;
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      HTRANS = HTRANS_IDLE;
      HWRITE = 1'b0;
      HSIZE  = HSIZE_BYTE;
      busy   = 1'b0;
      done   = 1'b0;
      case (state)
         COLLECT: busy = 1'b1;
         ADDR: begin
            busy   = 1'b1;
            HTRANS = HTRANS_NONSEQ;
            HWRITE = 1'b1;
            HSIZE  = HSIZE_WORD;
         end
         DATA:    busy = 1'b1;
         DONE:    done = 1'b1;
         default: busy = 1'b0;
      endcase
   end

   // Address follows the completed-word count, so it is naturally frozen while ADDR stalls.
   assign HADDR = BASE_ADDR + (32'(word_count) << 2);

   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         word_count <= '0;
         HWDATA     <= 32'd0;
      end else begin
         if (start_ok)       word_count <= '0;
         else if (data_done) word_count <= word_count + 1'b1;
         if (word_valid && collecting) HWDATA <= packed_word;
      end
   end

`ifdef AHB_STREAM_LOADER_CHECKSUM_EN
   always_ff @(posedge HCLK) begin
      if (HRESET)         checksum <= 32'd0;
      else if (start_ok)  checksum <= 32'd0;
      else if (data_done) checksum <= checksum + HWDATA;
   end
`endif

endmodule
